// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: bus directions, FSM state
// encodings and grant codes.
package mem_arb_pkg;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational tie-break between the instruction and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data wins every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  logic   last_d,
`endif
  output grant_t grant
);

  always_comb begin
    grant = GRANT_NONE;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      grant = last_d ? GRANT_I : GRANT_D;
`else
      grant = GRANT_D;
`endif
    end else if (i_req) begin
      grant = GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates bfcpu instruction fetch and data ports onto one single-port memory.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of data priority.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access in flight; pick a requester and launch m_req
// ST_BUSY_I | instruction fetch outstanding, m_* held until m_ack
// ST_BUSY_D | data access outstanding, m_* held until m_ack
// ST_DONE   | x_ack pulse cycle; no grant so a dropped req is not re-served
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int              M_AW   = 16,
  parameter logic [M_AW-1:0] I_BASE = M_AW'(16'h0000),
  parameter logic [M_AW-1:0] D_BASE = M_AW'(16'hFF00)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [15:0]     i_addr,
  output logic            i_ack,
  output logic [7:0]      i_rdata,
  input  logic            d_req,
  input  logic            d_dir,
  input  logic [7:0]      d_addr,
  input  logic [7:0]      d_wdata,
  output logic            d_ack,
  output logic [7:0]      d_rdata,
  output logic            m_req,
  output logic            m_dir,
  output logic [M_AW-1:0] m_addr,
  output logic [7:0]      m_wdata,
  input  logic            m_ack,
  input  logic [7:0]      m_rdata
);

  arb_state_t      state, state_nxt;
  grant_t          grant;
  logic            m_req_nxt, m_dir_nxt;
  logic [M_AW-1:0] m_addr_nxt;
  logic [7:0]      m_wdata_nxt;
  logic            i_ack_nxt, d_ack_nxt;
  logic [7:0]      i_rdata_nxt, d_rdata_nxt;
  logic [M_AW-1:0] i_maddr, d_maddr;

  // Both spaces wrap silently inside the memory address range.
  assign i_maddr = I_BASE + M_AW'(i_addr);
  assign d_maddr = D_BASE + M_AW'(d_addr);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // Reset to "data served last" so the instruction port wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (state == ST_IDLE && grant != GRANT_NONE) begin
      last_d <= (grant == GRANT_D);
    end
  end

  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last_d (last_d),
    .grant  (grant)
  );
`else
  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .grant  (grant)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    m_req_nxt   = m_req;
    m_dir_nxt   = m_dir;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    case (state)
      ST_IDLE: begin
        case (grant)
          GRANT_I: begin
            m_req_nxt   = 1'b1;
            m_dir_nxt   = DIRECTION_READ;
            m_addr_nxt  = i_maddr;
            m_wdata_nxt = 8'h00;
            state_nxt   = ST_BUSY_I;
          end
          GRANT_D: begin
            m_req_nxt   = 1'b1;
            m_dir_nxt   = d_dir;
            m_addr_nxt  = d_maddr;
            m_wdata_nxt = d_wdata;
            state_nxt   = ST_BUSY_D;
          end
          default: ;
        endcase
      end
      ST_BUSY_I: begin
        if (m_ack) begin
          m_req_nxt   = 1'b0;
          i_ack_nxt   = 1'b1;
          i_rdata_nxt = m_rdata;
          state_nxt   = ST_DONE;
        end
      end
      ST_BUSY_D: begin
        if (m_ack) begin
          m_req_nxt = 1'b0;
          d_ack_nxt = 1'b1;
          // A write completion leaves the last read byte visible.
          if (m_dir != DIRECTION_WRITE) begin
            d_rdata_nxt = m_rdata;
          end
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_req   <= 1'b0;
      m_dir   <= DIRECTION_READ;
      m_addr  <= '0;
      m_wdata <= 8'h00;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= 8'h00;
      d_rdata <= 8'h00;
    end else begin
      m_req   <= m_req_nxt;
      m_dir   <= m_dir_nxt;
      m_addr  <= m_addr_nxt;
      m_wdata <= m_wdata_nxt;
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      i_rdata <= i_rdata_nxt;
      d_rdata <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level reference model with a
// behavioural memory, plus a second instance built with a wrapping I_BASE.
module tb_mem_arb;

  localparam logic [15:0] I_BASE   = 16'h0000;
  localparam logic [15:0] D_BASE   = 16'hFF00;
  localparam logic [15:0] I_BASE_W = 16'hFFF0;
  localparam logic        RD = 1'b0;
  localparam logic        WR = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_dir = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic [7:0]  d_addr = 8'h0, d_wdata = 8'h0;
  logic        i_ack, d_ack, m_req, m_dir, m_ack;
  logic [7:0]  i_rdata, d_rdata, m_wdata, m_rdata;
  logic [15:0] m_addr;
  logic        w_i_ack, w_d_ack, w_m_req, w_m_dir;
  logic [7:0]  w_i_rdata, w_d_rdata, w_m_wdata;
  logic [15:0] w_m_addr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arb #(.M_AW(16), .I_BASE(I_BASE), .D_BASE(D_BASE)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_dir(m_dir), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  mem_arb #(.M_AW(16), .I_BASE(I_BASE_W), .D_BASE(D_BASE)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(w_d_ack), .d_rdata(w_d_rdata),
    .m_req(w_m_req), .m_dir(w_m_dir), .m_addr(w_m_addr), .m_wdata(w_m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  // Unwritten locations read a fixed address hash.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ---------------- behavioural memory (acks ack_dly cycles after m_req) ---
  int          ack_dly = 1;
  bit          stray_ack = 1'b0;
  bit          pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  logic [7:0]  mem [65536];
  bit          wr_v [65536];
  int          mcnt = 0;
  bit          served = 1'b0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] = pl_data;
      wr_v[pl_addr] = 1'b1;
    end
    m_ack <= stray_ack;
    if (!rst_n || !m_req) begin
      mcnt = 0;
      served = 1'b0;
    end else if (!served) begin
      mcnt = mcnt + 1;
      if (mcnt >= ack_dly) begin
        m_ack  <= 1'b1;
        served = 1'b1;
        m_rdata <= wr_v[m_addr] ? mem[m_addr] : init_byte(m_addr);
        if (m_dir == WR) begin
          mem[m_addr] = m_wdata;
          wr_v[m_addr] = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model state ----------------------------------
  logic [7:0] ref_mem [int];
  bit         last_d = 1'b1;
  logic [7:0] i_rd_model = 8'h00;
  logic [7:0] d_rd_model = 8'h00;

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[int'(a)] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic model_reset();
    last_d = 1'b1;
    i_rd_model = 8'h00;
    d_rd_model = 8'h00;
  endtask

  // Called at a negedge: drives requests, follows one transaction to its
  // ack and finishes at the negedge after the ack cycle (arbiter idle).
  task automatic run_txn(input string nm, input bit ri, input bit rd, input logic dir,
                         input logic [15:0] ia, input logic [7:0] da, input logic [7:0] wd,
                         input int dly, input bit drop, input bit stray);
    bit exp_d;
    logic [15:0] exp_addr;
    logic exp_dir;
    logic [7:0] exp_rd;
    int n;
    bit got;
    if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
      exp_d = !last_d;
`else
      exp_d = 1'b1;
`endif
    end else begin
      exp_d = rd;
    end
    exp_addr = exp_d ? 16'(D_BASE + {8'h00, da}) : 16'(I_BASE + ia);
    exp_dir  = exp_d ? dir : RD;
    i_req = ri; d_req = rd; d_dir = dir; i_addr = ia; d_addr = da; d_wdata = wd;
    ack_dly = dly;
    @(negedge clk);
    n_checks++;
    if ({m_req, m_addr, m_dir} !== {1'b1, exp_addr, exp_dir}) begin
      n_fail++;
      $display("FAIL %s grant: req/addr/dir got %b/%h/%b want 1/%h/%b", nm, m_req, m_addr, m_dir, exp_addr, exp_dir);
    end
    if (!exp_d || dir == WR) begin
      n_checks++;
      if (m_wdata !== (exp_d ? wd : 8'h00)) begin
        n_fail++;
        $display("FAIL %s wdata: got %h want %h", nm, m_wdata, exp_d ? wd : 8'h00);
      end
    end
    if (!exp_d) begin
      n_checks++;
      if (w_m_addr !== 16'(I_BASE_W + ia)) begin
        n_fail++;
        $display("FAIL %s wrap_addr: got %h want %h", nm, w_m_addr, 16'(I_BASE_W + ia));
      end
    end
    n = 1;
    got = 1'b0;
    while (!got && n < dly + 20) begin
      if (i_ack || d_ack) begin
        got = 1'b1;
      end else begin
        n_checks++;
        if (m_req !== 1'b1 || m_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s hold: cycle %0d req/addr got %b/%h want 1/%h", nm, n, m_req, m_addr, exp_addr);
        end
        if (stray && m_ack) stray_ack = 1'b1;
        @(negedge clk);
        n++;
      end
    end
    stray_ack = 1'b0;
    n_checks++;
    if (!got || n != dly + 2) begin
      n_fail++;
      $display("FAIL %s latency: ack after %0d cycles (seen=%0d) want %0d", nm, n, got, dly + 2);
    end
    n_checks++;
    if ({i_ack, d_ack, w_i_ack, w_d_ack} !== (exp_d ? 4'b0101 : 4'b1010)) begin
      n_fail++;
      $display("FAIL %s ack_port: got i/d=%b%b want d=%b", nm, i_ack, d_ack, exp_d);
    end
    if (exp_d) begin
      if (dir == WR) ref_mem[int'(exp_addr)] = wd;
      else d_rd_model = ref_read(exp_addr);
    end else begin
      i_rd_model = ref_read(exp_addr);
    end
    n_checks++;
    if ({i_rdata, d_rdata} !== {i_rd_model, d_rd_model}) begin
      n_fail++;
      $display("FAIL %s rdata: got i=%h d=%h want i=%h d=%h", nm, i_rdata, d_rdata, i_rd_model, d_rd_model);
    end
    last_d = exp_d;
    @(negedge clk);
    n_checks++;
    if ({i_ack, d_ack, m_req, i_rdata, d_rdata} !== {3'b000, i_rd_model, d_rd_model}) begin
      n_fail++;
      $display("FAIL %s after_ack: ack i/d=%b%b req=%b rdata=%h/%h want 0/0/0 %h/%h",
               nm, i_ack, d_ack, m_req, i_rdata, d_rdata, i_rd_model, d_rd_model);
    end
    if (drop) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic check_quiet(input string nm, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n_checks++;
      if ({i_ack, d_ack, m_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s quiet: cycle %0d ack i/d=%b%b req=%b want 000", nm, k, i_ack, d_ack, m_req);
      end
    end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({i_ack, d_ack, m_req, m_dir, m_addr, m_wdata, i_rdata, d_rdata} !== '0 ||
        {w_i_ack, w_d_ack, w_m_req, w_m_dir, w_m_addr, w_m_wdata, w_i_rdata, w_d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b dir=%b addr=%h wdata=%h ack=%b%b rdata=%h/%h want all 0",
               m_req, m_dir, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_instr_read();
    preload(16'h0012, 8'hA5);
    run_txn("ifetch", 1, 0, RD, 16'h0012, 8'h00, 8'h00, 1, 1, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (i_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL ifetch_hold: i_rdata got %h want a5", i_rdata);
    end
  endtask

  task automatic test_data_wr_rd();
    run_txn("dwrite", 0, 1, WR, 16'h0000, 8'h03, 8'h5C, 1, 1, 0);
    run_txn("dread", 0, 1, RD, 16'h0000, 8'h03, 8'h00, 1, 1, 0);
    n_checks++;
    if (d_rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL dread_value: d_rdata got %h want 5c", d_rdata);
    end
  endtask

  task automatic test_tie();
    for (int k = 0; k < 3; k++)
      run_txn("tie", 1, 1, RD, 16'h0100 + 16'(k), 8'h10 + 8'(k), 8'h00, 1, 0, 0);
    run_txn("tie_i_only", 1, 0, RD, 16'h0200, 8'h00, 8'h00, 1, 1, 0);
  endtask

  task automatic test_slow();
    run_txn("slow_i", 1, 0, RD, 16'h0345, 8'h00, 8'h00, 5, 1, 1);
    check_quiet("slow_i", 3);
    run_txn("slow_d", 0, 1, WR, 16'h0000, 8'h77, 8'hE1, 5, 1, 1);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check_quiet("idle_stray", 3);
  endtask

  task automatic test_reset_busy();
    i_req = 1'b0; d_req = 1'b1; d_dir = RD; d_addr = 8'h40; ack_dly = 8;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0;
    i_req = 1'b1;
    i_addr = 16'h0077;
    @(negedge clk);
    n_checks++;
    if ({i_ack, d_ack, m_req, m_dir, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL busy_reset: req=%b addr=%h ack=%b%b rdata=%h/%h want all 0",
               m_req, m_addr, i_ack, d_ack, i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    model_reset();
    run_txn("post_reset_i", 1, 0, RD, 16'h0077, 8'h00, 8'h00, 1, 1, 0);
  endtask

  task automatic test_wrap();
    run_txn("wrap", 1, 0, RD, 16'h0020, 8'h00, 8'h00, 1, 1, 0);
    run_txn("wrap_top", 1, 0, RD, 16'hFFFF, 8'h00, 8'h00, 2, 1, 0);
    run_txn("d_top", 0, 1, RD, 16'h0000, 8'hFF, 8'h00, 1, 1, 0);
  endtask

  task automatic test_random();
    bit ri, rd;
    for (int k = 0; k < 30; k++) begin
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      run_txn("random", ri, rd, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
              8'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_instr_read();
    test_data_wr_rd();
    test_tie();
    test_slow();
    test_reset_busy();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Shares one single-port unified memory between the bfcpu instruction fetch port (i_*) and data port (d_*).
- Replaces separate instruction and data memories on small boards.
- Arbitrates, maps both address spaces into one memory address range, and re-times the req/ack handshake on both sides.
- Sits between the bfcpu instance and a single memory model at the board top level.

Parameters:
- M_AW, 16, memory address width.
- I_BASE, 16'h0000, memory address of instruction byte 0.
- D_BASE, 16'hFF00, memory address of data byte 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  instruction fetch request (level)
- i_addr  in  16  instruction address
- i_ack  out  1  one-cycle fetch done pulse
- i_rdata  out  8  fetched byte, valid with i_ack, held afterwards
- d_req  in  1  data request (level)
- d_dir  in  1  DIRECTION_READ / DIRECTION_WRITE
- d_addr  in  8  data address
- d_wdata  in  8  write data
- d_ack  out  1  one-cycle data done pulse
- d_rdata  out  8  read byte, valid with d_ack, held afterwards
- m_req  out  1  memory request (level)
- m_dir  out  1  memory direction
- m_addr  out  M_AW  memory address
- m_wdata  out  8  memory write data
- m_ack  in  1  memory done pulse
- m_rdata  in  8  memory read data, valid with m_ack

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. All registers update on posedge clk only.
- Reset values:
  - i_ack=0, d_ack=0, m_req=0, m_dir=READ.
  - m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0.
  - State = IDLE; last-grant pointer = D, so I wins the first tie.
- Four states:
  - IDLE: if any request is pending, register the grant. Set m_req=1, load m_dir/m_addr/m_wdata, and go to BUSY_I or BUSY_D. With no request, stay in IDLE.
  - BUSY_I / BUSY_D: hold m_req and all m_* fields stable. On m_ack=1:
    - m_req<=0.
    - The granted x_ack<=1.
    - x_rdata<=m_rdata (for d writes, d_rdata is unchanged).
    - Go to DONE.
  - DONE: the ack pulse is visible for exactly this cycle. x_ack<=0 and go to IDLE. No grant is made in DONE, so a requester that drops req on the cycle after ack is not re-served.
- Grants are made only from IDLE; at most one memory transaction is outstanding.
- Latency with a memory that acks one cycle after m_req:
  - req rises in cycle 0;
  - m_req high in cycle 1;
  - m_ack in cycle 2;
  - x_ack in cycle 3;
  - earliest next grant in cycle 4.
- Address map:
  - Instruction: m_addr = (I_BASE + i_addr) truncated to M_AW; wrap-around is silent.
  - Data: m_addr = D_BASE + zero-extended d_addr, truncated to M_AW.
  - The instruction side is always READ, with m_wdata=0.
- Tie (both requests in IDLE): the policy is set by the Optional Feature.
- m_ack while in IDLE or DONE is ignored.
- If req drops during BUSY (requester contract violation), the transaction still completes and ack is still pulsed.
- Reset mid-transaction: outputs go to reset values on the next edge and the in-flight memory access is abandoned. The memory must accept m_req falling without an ack.
- Request inputs are sampled only in IDLE; addr/dir/wdata are captured at grant.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. On a tie, grant the port not served last. The pointer updates on every grant.
- Undefined: fixed priority, D always wins a tie. The pointer logic is not built.
- Grants without a tie are identical in both builds.

Decomposition:
- The DIRECTION_READ/DIRECTION_WRITE values come from the existing shared direction macros header.
- Add arbiter state encodings to a shared mem_arb header (IDLE, BUSY_I, BUSY_D, DONE).
- Sub-module mem_arb_pick: combinational tie-break from i_req, d_req and the pointer; produces the grant (none, I or D). It is the only part affected by MEM_ARB_RR_EN.

Test Plan:
1. Instruction read:
   - Stimulus: i_addr=16'h0012, memory [0x0012]=8'hA5, 1-cycle-ack memory.
   - Required: m_addr=0x0012 and m_dir=READ in cycle 1; i_ack pulses in cycle 3 with i_rdata=8'hA5; i_rdata holds afterwards.
2. Data write then read:
   - Stimulus: d_addr=8'h03, d_wdata=8'h5C, write; then read of d_addr=8'h03.
   - Required: write has m_addr=0xFF03 and m_wdata=8'h5C; the read returns d_rdata=8'h5C; d_rdata is unchanged during the write ack.
3. Tie:
   - Stimulus: i_req and d_req both held high for 3 transactions.
   - Required with MEM_ARB_RR_EN defined: grant order I, D, I.
   - Required with it undefined: D, D, D while d_req is held, I only once d_req drops.
4. Slow memory:
   - Stimulus: m_ack delayed 5 cycles.
   - Required: m_req/m_addr stable for all 5 cycles; exactly one x_ack pulse; a stray m_ack in DONE is ignored.
5. Reset in BUSY_D:
   - Stimulus: rst_n=0 for one cycle while in BUSY_D.
   - Required: all outputs 0 the next cycle, no d_ack; after release, a pending i_req is granted first.
6. Wrap-around:
   - Stimulus: I_BASE=16'hFFF0, i_addr=16'h0020.
   - Required: m_addr=16'h0010.
